// File: rtl/seq_loop_status_monitor_if.sv
// Sampled control signals of an HLS block plus the statistics the monitor reports back.
// Latency: none (wires only); backpressure: none, the monitor is a passive observer.
interface seq_loop_status_monitor_if #(
    parameter int STATE_W = 6,
    parameter int CNT_W   = 32
);
    logic               ap_start;
    logic               ap_ready;
    logic               ap_done;
    logic               ap_continue;
    logic               finish;
    logic [STATE_W-1:0] cur_state;
    logic [STATE_W-1:0] pre_loop_state0;
    logic               pre_states_valid;
    logic [STATE_W-1:0] post_loop_state0;
    logic               post_states_valid;
    logic [STATE_W-1:0] quit_loop_state0;
    logic               quit_states_valid;
    logic [STATE_W-1:0] iter_start_state;
    logic [STATE_W-1:0] iter_end_state0;
    logic               iter_end_states_valid;
    logic               one_state_loop;
    logic               one_state_block;

    logic               mod_busy;
    logic [CNT_W-1:0]   mod_start_cnt;
    logic [CNT_W-1:0]   mod_ready_cnt;
    logic [CNT_W-1:0]   mod_done_cnt;
    logic [CNT_W-1:0]   mod_busy_cycles;
    logic               loop_active;
    logic [CNT_W-1:0]   loop_invoc_cnt;
    logic [CNT_W-1:0]   iter_cnt;
    logic [CNT_W-1:0]   cur_trip_cnt;
    logic [CNT_W-1:0]   last_trip_cnt;
    logic [CNT_W-1:0]   cur_iter_lat;
    logic [CNT_W-1:0]   last_iter_lat;
    logic               frozen;

    modport slave (
        input  ap_start, ap_ready, ap_done, ap_continue, finish, cur_state,
               pre_loop_state0, pre_states_valid, post_loop_state0, post_states_valid,
               quit_loop_state0, quit_states_valid, iter_start_state, iter_end_state0,
               iter_end_states_valid, one_state_loop, one_state_block,
        output mod_busy, mod_start_cnt, mod_ready_cnt, mod_done_cnt, mod_busy_cycles,
               loop_active, loop_invoc_cnt, iter_cnt, cur_trip_cnt, last_trip_cnt,
               cur_iter_lat, last_iter_lat, frozen
    );

    modport master (
        output ap_start, ap_ready, ap_done, ap_continue, finish, cur_state,
               pre_loop_state0, pre_states_valid, post_loop_state0, post_states_valid,
               quit_loop_state0, quit_states_valid, iter_start_state, iter_end_state0,
               iter_end_states_valid, one_state_loop, one_state_block,
        input  mod_busy, mod_start_cnt, mod_ready_cnt, mod_done_cnt, mod_busy_cycles,
               loop_active, loop_invoc_cnt, iter_cnt, cur_trip_cnt, last_trip_cnt,
               cur_iter_lat, last_iter_lat, frozen
    );
endinterface

// File: rtl/seq_loop_status_monitor.sv
// Passive handshake and sequential-loop statistics monitor; all results registered, 1-cycle latency.
// Backpressure: none, never stalls the observed block; finish freezes every register until reset.
module seq_loop_status_monitor #(
    parameter int STATE_W = 6,
    parameter int CNT_W   = 32
) (
    input  logic clock,
    input  logic reset,
    seq_loop_status_monitor_if.slave mon
);
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} loop_state_t;

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + ONE;
    endfunction

    loop_state_t        loop_state;
    logic [STATE_W-1:0] prev_state;
    logic               frozen;
    logic               mod_busy;
    logic [CNT_W-1:0]   mod_start_cnt, mod_ready_cnt, mod_done_cnt, mod_busy_cycles;
    logic               loop_active;
    logic [CNT_W-1:0]   loop_invoc_cnt, iter_cnt, cur_trip_cnt, last_trip_cnt;
    logic [CNT_W-1:0]   cur_iter_lat, last_iter_lat;

    logic               done_acc, busy_nxt;
    logic               entry, active_cyc, iter_start, iter_end, loop_exit;
    logic [STATE_W-1:0] end_state;
    logic [CNT_W-1:0]   lat_now, trip_base;

    always_comb begin
        done_acc   = mon.ap_done && mon.ap_continue;
        // A start arriving with done keeps the block busy for the next transaction.
        busy_nxt   = done_acc ? mon.ap_start : (mod_busy || mon.ap_start);
        entry      = (loop_state == IDLE)
                  && (!mon.pre_states_valid || prev_state == mon.pre_loop_state0)
                  && (mon.cur_state == mon.iter_start_state)
                  && (prev_state != mon.iter_start_state);
        active_cyc = (loop_state == RUN) || entry;
        end_state  = mon.one_state_loop ? mon.iter_start_state : mon.iter_end_state0;
        iter_start = active_cyc && (mon.cur_state == mon.iter_start_state)
                  && (prev_state != mon.iter_start_state || mon.one_state_loop);
        iter_end   = active_cyc && (mon.cur_state == end_state)
                  && (mon.iter_end_states_valid || mon.one_state_loop);
        loop_exit  = (loop_state == RUN)
                  && (!mon.quit_states_valid || prev_state == mon.quit_loop_state0)
                  && (!mon.post_states_valid || mon.cur_state == mon.post_loop_state0)
                  && (mon.cur_state != mon.iter_start_state);
        // Latency including the current cycle, so an end cycle reports itself.
        lat_now    = iter_start ? ONE : sat_inc(cur_iter_lat);
        trip_base  = entry ? '0 : cur_trip_cnt;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            loop_state      <= IDLE;
            prev_state      <= '0;
            frozen          <= 1'b0;
            mod_busy        <= 1'b0;
            mod_start_cnt   <= '0;
            mod_ready_cnt   <= '0;
            mod_done_cnt    <= '0;
            mod_busy_cycles <= '0;
            loop_active     <= 1'b0;
            loop_invoc_cnt  <= '0;
            iter_cnt        <= '0;
            cur_trip_cnt    <= '0;
            last_trip_cnt   <= '0;
            cur_iter_lat    <= '0;
            last_iter_lat   <= '0;
        end else if (!frozen) begin
            frozen     <= mon.finish;
            prev_state <= mon.cur_state;
            mod_busy   <= busy_nxt;
            if (mon.ap_start && mon.ap_ready) mod_start_cnt <= sat_inc(mod_start_cnt);
            if (mon.ap_ready) mod_ready_cnt <= sat_inc(mod_ready_cnt);
            if (done_acc) mod_done_cnt <= sat_inc(mod_done_cnt);
            if (mon.ap_start || mod_busy) mod_busy_cycles <= sat_inc(mod_busy_cycles);

            if (mon.one_state_block) begin
                loop_state  <= IDLE;
                loop_active <= 1'b0;
            end else begin
                if (entry) begin
                    loop_state     <= RUN;
                    loop_active    <= 1'b1;
                    loop_invoc_cnt <= sat_inc(loop_invoc_cnt);
                end else if (loop_exit) begin
                    loop_state    <= IDLE;
                    loop_active   <= 1'b0;
                    last_trip_cnt <= cur_trip_cnt;
                end
                if (active_cyc) cur_iter_lat <= lat_now;
                if (iter_end) begin
                    iter_cnt      <= sat_inc(iter_cnt);
                    cur_trip_cnt  <= sat_inc(trip_base);
                    last_iter_lat <= lat_now;
                end else if (entry) begin
                    cur_trip_cnt <= '0;
                end
            end
        end
    end

    assign mon.frozen          = frozen;
    assign mon.mod_busy        = mod_busy;
    assign mon.mod_start_cnt   = mod_start_cnt;
    assign mon.mod_ready_cnt   = mod_ready_cnt;
    assign mon.mod_done_cnt    = mod_done_cnt;
    assign mon.mod_busy_cycles = mod_busy_cycles;
    assign mon.loop_active     = loop_active;
    assign mon.loop_invoc_cnt  = loop_invoc_cnt;
    assign mon.iter_cnt        = iter_cnt;
    assign mon.cur_trip_cnt    = cur_trip_cnt;
    assign mon.last_trip_cnt   = last_trip_cnt;
    assign mon.cur_iter_lat    = cur_iter_lat;
    assign mon.last_iter_lat   = last_iter_lat;
endmodule

// File: tb/tb_seq_loop_status_monitor.sv
// Directed bench for seq_loop_status_monitor: handshake, loop, freeze, reset and saturation vectors.
// Inputs driven and outputs sampled 1 time unit after each rising clock edge.
module tb_seq_loop_status_monitor;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    seq_loop_status_monitor_if #(.STATE_W(6), .CNT_W(32)) mif();
    seq_loop_status_monitor_if #(.STATE_W(6), .CNT_W(4))  sif();

    seq_loop_status_monitor #(.STATE_W(6), .CNT_W(32)) dut (
        .clock(clock), .reset(reset), .mon(mif.slave));
    seq_loop_status_monitor #(.STATE_W(6), .CNT_W(4)) dut_sat (
        .clock(clock), .reset(reset), .mon(sif.slave));

    localparam logic [5:0] S1 = 6'b000001, S2 = 6'b000010, S3 = 6'b000100;
    localparam logic [5:0] S4 = 6'b001000, S5 = 6'b010000, S6 = 6'b100000;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic go(input logic [5:0] s);
        mif.cur_state = s;
        tick();
    endtask

    task automatic randomize_inputs();
        mif.ap_start    = 1'($urandom);
        mif.ap_ready    = 1'($urandom);
        mif.ap_done     = 1'($urandom);
        mif.ap_continue = 1'($urandom);
        mif.finish      = 1'($urandom);
        mif.cur_state   = 6'($urandom);
    endtask

    initial begin
        reset = 1'b0;
        // loop configuration: enter from S1, iterate S2..S6, leave S2 -> S1
        mif.pre_loop_state0 = S1;  mif.pre_states_valid = 1'b1;
        mif.post_loop_state0 = S1; mif.post_states_valid = 1'b1;
        mif.quit_loop_state0 = S2; mif.quit_states_valid = 1'b1;
        mif.iter_start_state = S2;
        mif.iter_end_state0 = S6;  mif.iter_end_states_valid = 1'b1;
        mif.one_state_loop = 1'b0; mif.one_state_block = 1'b0;
        sif.ap_start = 1'b0; sif.ap_ready = 1'b0; sif.ap_done = 1'b0; sif.ap_continue = 1'b1;
        sif.finish = 1'b0; sif.cur_state = '0;
        sif.pre_loop_state0 = '0; sif.pre_states_valid = 1'b0;
        sif.post_loop_state0 = '0; sif.post_states_valid = 1'b0;
        sif.quit_loop_state0 = '0; sif.quit_states_valid = 1'b0;
        sif.iter_start_state = '0; sif.iter_end_state0 = '0; sif.iter_end_states_valid = 1'b0;
        sif.one_state_loop = 1'b0; sif.one_state_block = 1'b1;

        randomize_inputs();
        tick();
        randomize_inputs();
        tick();
        check_eq("rst_frozen", 32'(mif.frozen), 0);
        check_eq("rst_busy", 32'(mif.mod_busy), 0);
        check_eq("rst_start_cnt", mif.mod_start_cnt, 0);
        check_eq("rst_ready_cnt", mif.mod_ready_cnt, 0);
        check_eq("rst_busy_cycles", mif.mod_busy_cycles, 0);
        check_eq("rst_loop_active", 32'(mif.loop_active), 0);
        check_eq("rst_iter_cnt", mif.iter_cnt, 0);
        check_eq("rst_cur_iter_lat", mif.cur_iter_lat, 0);

        mif.ap_start = 1'b0; mif.ap_ready = 1'b0; mif.ap_done = 1'b0;
        mif.ap_continue = 1'b1; mif.finish = 1'b0; mif.cur_state = S1;
        reset = 1'b1;
        tick();

        // single transaction: start+ready in cycle 1, done in cycle 5
        mif.ap_start = 1'b1; mif.ap_ready = 1'b1;
        tick();
        mif.ap_start = 1'b0; mif.ap_ready = 1'b0;
        check_eq("txn_busy_set", 32'(mif.mod_busy), 1);
        repeat (3) tick();
        mif.ap_done = 1'b1;
        tick();
        mif.ap_done = 1'b0;
        check_eq("txn_start_cnt", mif.mod_start_cnt, 1);
        check_eq("txn_ready_cnt", mif.mod_ready_cnt, 1);
        check_eq("txn_done_cnt", mif.mod_done_cnt, 1);
        check_eq("txn_busy_cycles", mif.mod_busy_cycles, 5);
        check_eq("txn_busy_clear", 32'(mif.mod_busy), 0);

        // three-iteration loop
        go(S1);
        go(S2);
        check_eq("loop_entered", 32'(mif.loop_active), 1);
        check_eq("loop_invoc_1", mif.loop_invoc_cnt, 1);
        go(S3); go(S4); go(S5); go(S6);
        check_eq("loop_lat_first", mif.last_iter_lat, 5);
        check_eq("loop_trip_first", mif.cur_trip_cnt, 1);
        for (int i = 0; i < 2; i++) begin
            go(S2); go(S3); go(S4); go(S5); go(S6);
        end
        go(S2);
        go(S1);
        check_eq("loop_exit_active", 32'(mif.loop_active), 0);
        check_eq("loop_iter_cnt", mif.iter_cnt, 3);
        check_eq("loop_last_trip", mif.last_trip_cnt, 3);
        check_eq("loop_last_lat", mif.last_iter_lat, 5);
        check_eq("loop_invoc_after", mif.loop_invoc_cnt, 1);
        go(S1);

        // one-state loop, held 4 cycles in the iteration state
        mif.one_state_loop = 1'b1;
        go(S2); go(S2); go(S2); go(S2);
        go(S1);
        check_eq("osl_iter_cnt", mif.iter_cnt, 7);
        check_eq("osl_last_trip", mif.last_trip_cnt, 4);
        check_eq("osl_last_lat", mif.last_iter_lat, 1);
        check_eq("osl_invoc", mif.loop_invoc_cnt, 2);
        mif.one_state_loop = 1'b0;

        // loop tracking disabled
        mif.one_state_block = 1'b1;
        go(S2); go(S3);
        check_eq("blk_active", 32'(mif.loop_active), 0);
        go(S1);
        check_eq("blk_invoc", mif.loop_invoc_cnt, 2);
        mif.one_state_block = 1'b0;
        go(S1);

        // finish mid-loop; the finish-cycle events still count
        go(S2); go(S3);
        mif.finish = 1'b1; mif.ap_ready = 1'b1;
        go(S4);
        mif.finish = 1'b0;
        go(S5); go(S6);
        mif.ap_start = 1'b1;
        go(S2);
        mif.ap_start = 1'b0; mif.ap_ready = 1'b0;
        check_eq("frz_frozen", 32'(mif.frozen), 1);
        check_eq("frz_cur_lat", mif.cur_iter_lat, 3);
        check_eq("frz_iter_cnt", mif.iter_cnt, 7);
        check_eq("frz_invoc", mif.loop_invoc_cnt, 3);
        check_eq("frz_active", 32'(mif.loop_active), 1);
        check_eq("frz_ready_cnt", mif.mod_ready_cnt, 2);
        check_eq("frz_start_cnt", mif.mod_start_cnt, 1);
        check_eq("frz_busy", 32'(mif.mod_busy), 0);

        reset = 1'b0;
        tick();
        check_eq("clr_frozen", 32'(mif.frozen), 0);
        check_eq("clr_iter_cnt", mif.iter_cnt, 0);
        check_eq("clr_ready_cnt", mif.mod_ready_cnt, 0);
        check_eq("clr_active", 32'(mif.loop_active), 0);
        check_eq("clr_last_lat", mif.last_iter_lat, 0);
        reset = 1'b1;
        mif.cur_state = S1;
        tick();

        // saturation on the 4-bit instance
        sif.ap_ready = 1'b1;
        repeat (15) tick();
        check_eq("sat_ready_15", 32'(sif.mod_ready_cnt), 15);
        repeat (5) tick();
        sif.ap_ready = 1'b0;
        check_eq("sat_ready_20", 32'(sif.mod_ready_cnt), 15);
        check_eq("sat_start_cnt", 32'(sif.mod_start_cnt), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/seq_loop_status_monitor.md
Name: seq_loop_status_monitor

Overview:
- Synthesizable, non-intrusive performance monitor that sits beside an HLS-generated block and samples its control signals.
- Module-status section: tracks the ap_start/ap_ready/ap_done/ap_continue handshake and counts transactions and busy cycles.
- Sequential-loop section: watches the block's FSM state register, detects loop entry, iterations and exit, and reports trip counts and per-iteration latency.
- A finish input freezes all results for readout.

Parameters:
- STATE_W, 6, width of the FSM state encoding (one-hot state constants).
- CNT_W, 32, width of every counter and latency output.

Ports:
- clock  in  1  single system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- ap_start  in  1  monitored block start.
- ap_ready  in  1  monitored block ready.
- ap_done  in  1  monitored block done.
- ap_continue  in  1  monitored block continue; tie to 1 when unused.
- finish  in  1  end of sampling; freezes all state.
- cur_state  in  STATE_W  monitored FSM current state.
- pre_loop_state0 / pre_states_valid  in  STATE_W/1  state preceding loop entry, and its qualifier.
- post_loop_state0 / post_states_valid  in  STATE_W/1  state reached after loop exit, and its qualifier.
- quit_loop_state0 / quit_states_valid  in  STATE_W/1  state from which the loop exits, and its qualifier.
- iter_start_state  in  STATE_W  first state of an iteration.
- iter_end_state0 / iter_end_states_valid  in  STATE_W/1  last state of an iteration, and its qualifier.
- one_state_loop  in  1  iteration is a single state.
- one_state_block  in  1  disables loop tracking.
- mod_busy  out  1  module transaction in flight.
- mod_start_cnt, mod_ready_cnt, mod_done_cnt, mod_busy_cycles  out  CNT_W  module handshake statistics.
- loop_active  out  1  loop currently executing.
- loop_invoc_cnt, iter_cnt, cur_trip_cnt, last_trip_cnt, cur_iter_lat, last_iter_lat  out  CNT_W  loop statistics.
- frozen  out  1  finish has been seen.

Behaviour:
- Reset: when reset==0 at a clock edge, all outputs, prev_state and internal state go to 0; loop FSM goes to IDLE. Reset overrides everything, including mid-loop and while frozen.
- Freeze: frozen sets on the first cycle with finish==1 and is sticky until reset. While frozen==1, no register changes. Events in the finish cycle itself are still counted.
- Saturation: all counters saturate at 2^CNT_W-1 and never wrap.
- mod_start_cnt: +1 on each cycle with ap_start&&ap_ready.
- mod_ready_cnt: +1 on each cycle with ap_ready (independent of ap_start).
- mod_done_cnt: +1 on each cycle with ap_done&&ap_continue.
- mod_busy: set the cycle after ap_start==1 with mod_busy==0; cleared the cycle after ap_done&&ap_continue. Simultaneous set and clear (ap_start together with done) leaves mod_busy=1, i.e. back-to-back transactions.
- mod_busy_cycles: +1 on every cycle where ap_start||mod_busy.
- prev_state: registers cur_state every cycle. State matches use full-vector equality.
- Loop FSM, IDLE -> RUN: on (!pre_states_valid || prev_state==pre_loop_state0) && cur_state==iter_start_state && prev_state!=iter_start_state.
  - Next cycle: loop_active=1, loop_invoc_cnt+1, cur_trip_cnt=0.
- Iteration start (RUN or entry cycle): cur_state==iter_start_state && (prev_state!=iter_start_state || one_state_loop). Sets cur_iter_lat=1.
- cur_iter_lat: +1 each cycle otherwise while RUN.
- Iteration end: cur_state==(one_state_loop ? iter_start_state : iter_end_state0) && (iter_end_states_valid || one_state_loop). Effects next cycle:
  - iter_cnt+1, cur_trip_cnt+1.
  - last_iter_lat=cur_iter_lat, counting the end cycle.
- RUN -> IDLE: on (!quit_states_valid || prev_state==quit_loop_state0) && (!post_states_valid || cur_state==post_loop_state0) && cur_state!=iter_start_state.
  - Next cycle: last_trip_cnt=cur_trip_cnt, loop_active=0.
  - Exit and re-entry in consecutive cycles are both honoured.
- one_state_block==1: loop FSM is forced to IDLE; loop counters are held.

Test Plan:
- Reset then hold: assert reset=0 for 2 cycles with random inputs -> all outputs 0, frozen=0.
- Single transaction: ap_start=1 with ap_ready=1 in cycle 1, ap_done=1 with ap_continue=1 in cycle 5 -> mod_start_cnt=1, mod_done_cnt=1, mod_busy_cycles=5, mod_busy=0 after cycle 6.
- Loop of 3 iterations, states one-hot 6-bit: state1=000001, states 2..6 in sequence, each iteration 2->6; pre=post=state1, quit=state2 -> loop_invoc_cnt=1, iter_cnt=3, last_trip_cnt=3, last_iter_lat=5, loop_active=0 after exit.
- one_state_loop=1, cur_state held at iter_start for 4 cycles -> iter_cnt=4, last_iter_lat=1.
- finish pulse mid-loop, then more activity -> frozen=1 and every counter unchanged afterwards; reset=0 clears frozen and counters.
- Saturation with CNT_W=4: 20 ready pulses -> mod_ready_cnt=15.
